// File: rtl/spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl
//
// Single-port RAM endpoint that sits behind an SPI slave. Each rx_valid strobe
// delivers one command frame: din[WORD_SIZE+1:WORD_SIZE] is the opcode and the
// low WORD_SIZE bits are the payload.
//   00 set write address   01 write data   10 set read address   11 read data
// A command-sequencing FSM (IDLE / WR_ARMED / RD_ARMED) decides which data
// commands are legal. Illegal frames and out-of-range addresses pulse err.
//
// Optional feature macro: SPI_RAM_AUTO_INC_EN
//   When defined, the write/read address advances (wrapping at MEM_DEPTH-1)
//   after every accepted data command, so a burst needs one address command.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   din       in   [WORD_SIZE+1:0] command frame (opcode + payload)
//   rx_valid  in   frame strobe, din is sampled only while high
//   dout      out  [WORD_SIZE-1:0] read data, held until the next read
//   tx_valid  out  one-cycle pulse, dout valid
//   err       out  one-cycle pulse, frame rejected
// -----------------------------------------------------------------------------
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE+1:0] din,
    input  logic                 rx_valid,
    output logic [WORD_SIZE-1:0] dout,
    output logic                 tx_valid,
    output logic                 err
);

    localparam logic [1:0] OP_SET_WR  = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_SET_RD  = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // Depth widened by one bit so the full payload can be range-checked.
    localparam logic [WORD_SIZE:0] DEPTH_EXT = (WORD_SIZE + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WR_ARMED = 2'b01,
        RD_ARMED = 2'b10
    } state_t;

    state_t               state_r;
    logic [ADDR_SIZE-1:0] wr_addr_r;
    logic [ADDR_SIZE-1:0] rd_addr_r;
    logic [WORD_SIZE-1:0] mem_r [MEM_DEPTH];

    logic [1:0]           opcode_s;
    logic [WORD_SIZE-1:0] payload_s;
    logic [ADDR_SIZE-1:0] addr_s;
    logic                 in_range_s;
    logic                 wr_en_s;
    logic [ADDR_SIZE-1:0] wr_addr_next_s;
    logic [ADDR_SIZE-1:0] rd_addr_next_s;

    // Frame decode and RAM write enable (reset wins over a frame in flight).
    always_comb begin
        opcode_s   = din[WORD_SIZE+1:WORD_SIZE];
        payload_s  = din[WORD_SIZE-1:0];
        addr_s     = din[ADDR_SIZE-1:0];
        in_range_s = ({1'b0, payload_s} < DEPTH_EXT);
        if (rx_valid && !rst && (opcode_s == OP_WR_DATA) && (state_r == WR_ARMED)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

`ifdef SPI_RAM_AUTO_INC_EN
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    // Post-access address: advance by one, wrapping at the last word.
    always_comb begin
        if (wr_addr_r == LAST_ADDR) begin
            wr_addr_next_s = {ADDR_SIZE{1'b0}};
        end else begin
            wr_addr_next_s = wr_addr_r + ADDR_SIZE'(1);
        end
        if (rd_addr_r == LAST_ADDR) begin
            rd_addr_next_s = {ADDR_SIZE{1'b0}};
        end else begin
            rd_addr_next_s = rd_addr_r + ADDR_SIZE'(1);
        end
    end
`else
    // Post-access address: unchanged, repeated data commands hit one word.
    always_comb begin
        wr_addr_next_s = wr_addr_r;
        rd_addr_next_s = rd_addr_r;
    end
`endif

    // RAM write port; contents are intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_r] <= payload_s;
        end
    end

    // Command FSM with address registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            wr_addr_r <= {ADDR_SIZE{1'b0}};
            rd_addr_r <= {ADDR_SIZE{1'b0}};
            dout      <= {WORD_SIZE{1'b0}};
            tx_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            err      <= 1'b0;
            if (rx_valid) begin
                case (opcode_s)
                    OP_SET_WR: begin
                        // Out-of-range address keeps both address and state.
                        if (in_range_s) begin
                            wr_addr_r <= addr_s;
                            state_r   <= WR_ARMED;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    OP_WR_DATA: begin
                        // The RAM write itself is issued through wr_en_s.
                        if (state_r == WR_ARMED) begin
                            wr_addr_r <= wr_addr_next_s;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    OP_SET_RD: begin
                        if (in_range_s) begin
                            rd_addr_r <= addr_s;
                            state_r   <= RD_ARMED;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    OP_RD_DATA: begin
                        // Payload of a read frame is ignored.
                        if (state_r == RD_ARMED) begin
                            dout      <= mem_r[rd_addr_r];
                            tx_valid  <= 1'b1;
                            rd_addr_r <= rd_addr_next_s;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: begin
                        err <= 1'b1;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_ctrl
//
// Self-checking bench for spi_ram_ctrl. Two instances share clock and reset:
// u_dut_a uses the default 256-word configuration, u_dut_b uses MEM_DEPTH=200
// for the address range checks. Every frame pushes its expected
// {tx_valid, err, dout} to a scoreboard queue; the outputs sampled 1 time unit
// after the capturing edge go to an observation queue, and each test task
// drains and compares both queues. Expectations for bursts follow
// SPI_RAM_AUTO_INC_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_spi_ram_ctrl;

    typedef struct {
        logic       tx;
        logic       er;
        logic [7:0] d;
        string      nm;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din_a, din_b;
    logic       rx_a, rx_b;
    logic [7:0] dout_a, dout_b;
    logic       tx_a, tx_b, err_a, err_b;

    rec_t       sb[$];
    rec_t       ob[$];
    logic [7:0] exp_dout [2];
    int         n_cmp = 0;
    int         n_bad = 0;

    spi_ram_ctrl u_dut_a (
        .clk(clk), .rst(rst), .din(din_a), .rx_valid(rx_a),
        .dout(dout_a), .tx_valid(tx_a), .err(err_a)
    );

    spi_ram_ctrl #(.MEM_DEPTH(200)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_b), .rx_valid(rx_b),
        .dout(dout_b), .tx_valid(tx_b), .err(err_b)
    );

    always #5 clk = ~clk;

    // Drive one cycle on instance inst, push the expectation, record outputs.
    task automatic xfer(input int inst, input logic rx, input logic [1:0] op,
                        input logic [7:0] pl, input logic etx, input logic eer,
                        input logic [7:0] rdv, input string nm);
        rec_t e;
        rec_t o;
        if (etx) exp_dout[inst] = rdv;
        e.tx = etx; e.er = eer; e.d = exp_dout[inst]; e.nm = nm;
        sb.push_back(e);
        if (inst == 0) begin din_a = {op, pl}; rx_a = rx; end
        else           begin din_b = {op, pl}; rx_b = rx; end
        @(posedge clk);
        #1;
        if (inst == 0) begin o.tx = tx_a; o.er = err_a; o.d = dout_a; end
        else           begin o.tx = tx_b; o.er = err_b; o.d = dout_b; end
        o.nm = nm;
        ob.push_back(o);
        rx_a = 1'b0;
        rx_b = 1'b0;
    endtask

    task automatic test_reset();
        rec_t e, o;
        rst = 1'b1;
        exp_dout[0] = 8'h00;
        exp_dout[1] = 8'h00;
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 8'h00, "rst_drop_read");
        xfer(0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 8'h00, "rst_drop_setrd");
        rst = 1'b0;
        xfer(0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, "reset_state");
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b0, 1'b1, 8'h00, "read_in_idle_err");
        xfer(0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, "err_one_cycle");
        xfer(0, 1'b1, 2'b01, 8'h5A, 1'b0, 1'b1, 8'h00, "write_in_idle_err");
        xfer(1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, "reset_state_b");
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_cmp++;
            if (o.tx !== e.tx || o.er !== e.er || o.d !== e.d) begin
                n_bad++;
                $display("FAIL %s: got tx=%b err=%b dout=%h, want tx=%b err=%b dout=%h",
                         e.nm, o.tx, o.er, o.d, e.tx, e.er, e.d);
            end
        end
    endtask

    task automatic test_write_read();
        rec_t e, o;
        xfer(0, 1'b1, 2'b00, 8'h05, 1'b0, 1'b0, 8'h00, "set_wr_05");
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b0, 1'b1, 8'h00, "read_in_wr_armed_err");
        xfer(0, 1'b1, 2'b01, 8'hA5, 1'b0, 1'b0, 8'h00, "write_a5");
        xfer(0, 1'b1, 2'b10, 8'h05, 1'b0, 1'b0, 8'h00, "set_rd_05");
        xfer(0, 1'b1, 2'b11, 8'hFF, 1'b1, 1'b0, 8'hA5, "read_05");
        xfer(0, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0, 8'h00, "tx_one_cycle");
        xfer(0, 1'b1, 2'b01, 8'h3C, 1'b0, 1'b1, 8'h00, "write_in_rd_armed_err");
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_cmp++;
            if (o.tx !== e.tx || o.er !== e.er || o.d !== e.d) begin
                n_bad++;
                $display("FAIL %s: got tx=%b err=%b dout=%h, want tx=%b err=%b dout=%h",
                         e.nm, o.tx, o.er, o.d, e.tx, e.er, e.d);
            end
        end
    endtask

    task automatic test_range();
        rec_t e, o;
        xfer(1, 1'b1, 2'b00, 8'h10, 1'b0, 1'b0, 8'h00, "b_set_wr_10");
        xfer(1, 1'b1, 2'b01, 8'h77, 1'b0, 1'b0, 8'h00, "b_write_77");
        xfer(1, 1'b1, 2'b00, 8'hC7, 1'b0, 1'b0, 8'h00, "b_set_wr_c7");
        xfer(1, 1'b1, 2'b01, 8'h99, 1'b0, 1'b0, 8'h00, "b_write_99");
        xfer(1, 1'b1, 2'b10, 8'h10, 1'b0, 1'b0, 8'h00, "b_set_rd_10");
        xfer(1, 1'b1, 2'b10, 8'hC8, 1'b0, 1'b1, 8'h00, "b_set_rd_c8_err");
        xfer(1, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'h77, "b_rd_addr_kept");
        xfer(1, 1'b1, 2'b10, 8'hC7, 1'b0, 1'b0, 8'h00, "b_set_rd_c7_ok");
        xfer(1, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'h99, "b_read_c7");
        xfer(1, 1'b1, 2'b00, 8'hFF, 1'b0, 1'b1, 8'h00, "b_set_wr_ff_err");
        xfer(1, 1'b1, 2'b01, 8'h12, 1'b0, 1'b1, 8'h00, "b_state_kept_rd");
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_cmp++;
            if (o.tx !== e.tx || o.er !== e.er || o.d !== e.d) begin
                n_bad++;
                $display("FAIL %s: got tx=%b err=%b dout=%h, want tx=%b err=%b dout=%h",
                         e.nm, o.tx, o.er, o.d, e.tx, e.er, e.d);
            end
        end
    endtask

    task automatic test_hold();
        rec_t e, o;
        xfer(0, 1'b1, 2'b00, 8'h31, 1'b0, 1'b0, 8'h00, "set_wr_31");
        xfer(0, 1'b1, 2'b01, 8'h55, 1'b0, 1'b0, 8'h00, "write_55");
        xfer(0, 1'b1, 2'b00, 8'h30, 1'b0, 1'b0, 8'h00, "set_wr_30");
        xfer(0, 1'b1, 2'b01, 8'h11, 1'b0, 1'b0, 8'h00, "write_11");
        xfer(0, 1'b1, 2'b00, 8'h30, 1'b0, 1'b0, 8'h00, "rearm_wr_30");
        for (int i = 0; i < 3; i++) begin
            xfer(0, 1'b0, 2'b01, 8'hEE, 1'b0, 1'b0, 8'h00, $sformatf("hold_%0d", i));
        end
        xfer(0, 1'b1, 2'b10, 8'h30, 1'b0, 1'b0, 8'h00, "set_rd_30");
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'h11, "no_write_while_low");
        xfer(0, 1'b1, 2'b00, 8'h30, 1'b0, 1'b0, 8'h00, "set_wr_30b");
        xfer(0, 1'b1, 2'b01, 8'hEE, 1'b0, 1'b0, 8'h00, "single_write_ee");
        xfer(0, 1'b1, 2'b10, 8'h30, 1'b0, 1'b0, 8'h00, "set_rd_30b");
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'hEE, "read_30_ee");
        xfer(0, 1'b1, 2'b10, 8'h31, 1'b0, 1'b0, 8'h00, "set_rd_31");
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'h55, "read_31_untouched");
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_cmp++;
            if (o.tx !== e.tx || o.er !== e.er || o.d !== e.d) begin
                n_bad++;
                $display("FAIL %s: got tx=%b err=%b dout=%h, want tx=%b err=%b dout=%h",
                         e.nm, o.tx, o.er, o.d, e.tx, e.er, e.d);
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t e, o;
        xfer(0, 1'b1, 2'b00, 8'hFE, 1'b0, 1'b0, 8'h00, "burst_set_wr_fe");
        xfer(0, 1'b1, 2'b01, 8'h11, 1'b0, 1'b0, 8'h00, "burst_wr_11");
        xfer(0, 1'b1, 2'b01, 8'h22, 1'b0, 1'b0, 8'h00, "burst_wr_22");
        xfer(0, 1'b1, 2'b01, 8'h33, 1'b0, 1'b0, 8'h00, "burst_wr_33");
        xfer(0, 1'b1, 2'b10, 8'hFE, 1'b0, 1'b0, 8'h00, "burst_set_rd_fe");
`ifdef SPI_RAM_AUTO_INC_EN
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'h11, "burst_rd_fe");
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'h22, "burst_rd_ff");
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'h33, "burst_rd_00_wrap");
        xfer(0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 8'h00, "set_rd_00");
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'h33, "direct_rd_00");
        xfer(0, 1'b1, 2'b10, 8'hFF, 1'b0, 1'b0, 8'h00, "set_rd_ff");
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'h22, "direct_rd_ff");
`else
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'h33, "repeat_rd_1");
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'h33, "repeat_rd_2");
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'h33, "repeat_rd_3");
`endif
        xfer(0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, "burst_end_idle");
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_cmp++;
            if (o.tx !== e.tx || o.er !== e.er || o.d !== e.d) begin
                n_bad++;
                $display("FAIL %s: got tx=%b err=%b dout=%h, want tx=%b err=%b dout=%h",
                         e.nm, o.tx, o.er, o.d, e.tx, e.er, e.d);
            end
        end
    endtask

    task automatic test_reset_between();
        rec_t e, o;
        xfer(0, 1'b1, 2'b00, 8'h40, 1'b0, 1'b0, 8'h00, "set_wr_40");
        xfer(0, 1'b1, 2'b01, 8'h5A, 1'b0, 1'b0, 8'h00, "write_5a");
        xfer(0, 1'b1, 2'b00, 8'h40, 1'b0, 1'b0, 8'h00, "rearm_wr_40");
        rst = 1'b1;
        exp_dout[0] = 8'h00;
        exp_dout[1] = 8'h00;
        xfer(0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, "mid_reset_outputs");
        rst = 1'b0;
        xfer(0, 1'b1, 2'b01, 8'hA1, 1'b0, 1'b1, 8'h00, "write_after_rst_err");
        xfer(0, 1'b1, 2'b10, 8'h40, 1'b0, 1'b0, 8'h00, "set_rd_40");
        xfer(0, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'h5A, "mem_unchanged_40");
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = ob.pop_front(); n_cmp++;
            if (o.tx !== e.tx || o.er !== e.er || o.d !== e.d) begin
                n_bad++;
                $display("FAIL %s: got tx=%b err=%b dout=%h, want tx=%b err=%b dout=%h",
                         e.nm, o.tx, o.er, o.d, e.tx, e.er, e.d);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        din_a = 10'h000;
        din_b = 10'h000;
        rx_a  = 1'b0;
        rx_b  = 1'b0;
        test_reset();
        test_write_read();
        test_range();
        test_hold();
        test_back_to_back();
        test_reset_between();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
